// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- UART receiver, 8N1 / 8N2, LSB first, programmable bit divider.
//
// The serial input is synchronised, and a start bit is accepted on a falling
// edge of the synchronised line. The start bit is confirmed at its midpoint.
// Data and stop bits are then sampled at their midpoints. Each good frame
// updates rx_data and produces a one-cycle rx_valid pulse. A frame with a low
// stop bit, or a frame aborted by the enable, leaves rx_data untouched.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst_b      asynchronous reset, active high
//   cfg_div    clock cycles per bit (>= 4), static during a frame
//   cfg_rxen   receiver enable; low forces IDLE at once
//   cfg_nstop  0 = one stop bit, 1 = two stop bits
//   uart_rxd   serial line, idle high
//   rx_valid   one-cycle pulse, rx_data holds a new byte
//   rx_data    last good byte received
// -----------------------------------------------------------------------------
module uart_rx (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [15:0] cfg_div,
  input  logic        cfg_rxen,
  input  logic        cfg_nstop,
  input  logic        uart_rxd,
  output logic        rx_valid,
  output logic [7:0]  rx_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Synchroniser and edge-detect history. All three flops reset to 1 so that
  // reset looks like an idle line, and no edge is seen when reset is released.
  logic        rxd_meta;
  logic        rxd_s;
  logic        rxd_prev;

  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic        stop_idx;
  logic [7:0]  shift_reg;

  // Control strobes from the FSM to the datapath.
  logic        cnt_clr;
  logic        bit_idx_clr;
  logic        shift_en;
  logic        stop_clr;
  logic        stop_set;
  logic        deliver;

  logic        start_edge;
  logic        half_tick;
  logic        bit_tick;

  // A start bit is accepted only on a 1->0 transition. This applies after a
  // framing error, after re-enable mid-frame, and after reset.
  assign start_edge = cfg_rxen && rxd_prev && !rxd_s;
  assign half_tick  = (baud_cnt == (cfg_div >> 1));
  assign bit_tick   = (baud_cnt == (cfg_div - 16'd1));

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes this a shift chain.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_s    <= rxd_meta;
      rxd_prev <= rxd_s;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and datapath strobes
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    cnt_clr     = 1'b0;
    bit_idx_clr = 1'b0;
    shift_en    = 1'b0;
    stop_clr    = 1'b0;
    stop_set    = 1'b0;
    deliver     = 1'b0;

    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (start_edge) begin
          state_nxt = START;
        end
      end

      START: begin
        if (half_tick) begin
          cnt_clr = 1'b1;
          if (rxd_s) begin
            // The line went high again before mid start bit, so this was a glitch.
            state_nxt = IDLE;
          end else begin
            bit_idx_clr = 1'b1;
            state_nxt   = DATA;
          end
        end
      end

      DATA: begin
        if (bit_tick) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
            stop_clr  = 1'b1;
            state_nxt = STOP;
          end
        end
      end

      STOP: begin
        if (bit_tick) begin
          cnt_clr = 1'b1;
          if (!rxd_s) begin
            // Framing error: the byte is dropped silently.
            state_nxt = IDLE;
          end else if (!cfg_nstop || stop_idx) begin
            // Return at mid stop bit, so a following start edge is not missed.
            deliver   = 1'b1;
            state_nxt = IDLE;
          end else begin
            stop_set = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // The disable overrides everything, and it abandons any frame in progress.
    if (!cfg_rxen) begin
      state_nxt   = IDLE;
      cnt_clr     = 1'b1;
      bit_idx_clr = 1'b0;
      shift_en    = 1'b0;
      stop_clr    = 1'b0;
      stop_set    = 1'b0;
      deliver     = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Counters and shift register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      baud_cnt  <= 16'd0;
      bit_idx   <= 3'd0;
      stop_idx  <= 1'b0;
      shift_reg <= 8'h00;
    end else begin
      if (cnt_clr) begin
        baud_cnt <= 16'd0;
      end else begin
        baud_cnt <= baud_cnt + 16'd1;
      end

      if (bit_idx_clr) begin
        bit_idx <= 3'd0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 3'd1;
      end

      if (shift_en) begin
        shift_reg[bit_idx] <= rxd_s;
      end

      if (stop_clr) begin
        stop_idx <= 1'b0;
      end else if (stop_set) begin
        stop_idx <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register: rx_data changes only together with an rx_valid pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
    end else begin
      rx_valid <= deliver;
      if (deliver) begin
        rx_data <= shift_reg;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- directed, self-checking bench for uart_rx.
// The line is driven on falling clock edges. A monitor logs every rx_valid
// pulse, together with its byte and cycle stamp, on falling edges. Each
// scenario task compares the log against hand-computed bytes.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic [15:0] cfg_div = 16'd869;
  logic        cfg_rxen = 1'b1;
  logic        cfg_nstop = 1'b0;
  logic        uart_rxd = 1'b1;
  logic        rx_valid;
  logic [7:0]  rx_data;

  int          errors = 0;
  int          checks = 0;
  longint      cyc = 0;
  longint      fall_cyc = 0;
  int          dbl = 0;
  logic        valid_d = 1'b0;
  logic [7:0]  got_q[$];
  longint      got_cyc[$];

  uart_rx dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .cfg_div   (cfg_div),
    .cfg_rxen  (cfg_rxen),
    .cfg_nstop (cfg_nstop),
    .uart_rxd  (uart_rxd),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      got_q.push_back(rx_data);
      got_cyc.push_back(cyc);
    end
    if (rx_valid && valid_d) dbl++;
    valid_d = rx_valid;
  end

  // Drive one frame. abort_bit >= 0 drops cfg_rxen at the start of that data bit.
  task automatic send_frame(input logic [7:0] b, input int div, input bit two_stop,
                            input bit bad_stop, input int abort_bit);
    cfg_div   = div[15:0];
    cfg_nstop = two_stop;
    @(negedge clk);
    uart_rxd = 1'b0;
    fall_cyc = cyc;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_bit) cfg_rxen = 1'b0;
      uart_rxd = b[i];
      repeat (div) @(negedge clk);
    end
    uart_rxd = !bad_stop;
    repeat (two_stop ? 2 * div : div) @(negedge clk);
    uart_rxd = 1'b1;
  endtask

  task automatic test_reset;
    rst_b = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b want 0", rx_valid);
    end
    checks++;
    if (rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h want 00", rx_data);
    end
    rst_b = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic;
    longint delta;
    got_q.delete();
    got_cyc.delete();
    send_frame(8'hA5, 869, 1'b0, 1'b0, -1);
    repeat (20) @(negedge clk);
    checks++;
    if (got_q.size() !== 1) begin
      errors++;
      $display("FAIL basic_count: got %0d want 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 8'hA5) begin
        errors++;
        $display("FAIL basic_data: got %h want a5", got_q[0]);
      end
      // The pulse must land inside the stop bit, which spans (9*div, 10*div].
      delta = got_cyc[0] - fall_cyc;
      checks++;
      if (delta <= 9 * 869 || delta > 10 * 869) begin
        errors++;
        $display("FAIL basic_timing: got %0d cycles want in (7821,8690]", delta);
      end
    end
  endtask

  task automatic test_stream;
    logic [7:0] tbl [16] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h7F, 8'hFE,
                             8'h3C, 8'hC3, 8'h12, 8'h34, 8'h9A, 8'hBC, 8'hE7, 8'h18};
    got_q.delete();
    got_cyc.delete();
    for (int i = 0; i < 16; i++) send_frame(tbl[i], 16, 1'b0, 1'b0, -1);
    repeat (20) @(negedge clk);
    checks++;
    if (got_q.size() !== 16) begin
      errors++;
      $display("FAIL stream_count: got %0d want 16", got_q.size());
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= got_q.size()) begin
        errors++;
        $display("FAIL stream_byte%0d: got none want %h", i, tbl[i]);
      end else if (got_q[i] !== tbl[i]) begin
        errors++;
        $display("FAIL stream_byte%0d: got %h want %h", i, got_q[i], tbl[i]);
      end
    end
  endtask

  task automatic test_min_div;
    got_q.delete();
    got_cyc.delete();
    send_frame(8'h5A, 4, 1'b0, 1'b0, -1);
    send_frame(8'h96, 4, 1'b0, 1'b0, -1);
    repeat (20) @(negedge clk);
    checks++;
    if (got_q.size() !== 2) begin
      errors++;
      $display("FAIL mindiv_count: got %0d want 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 8'h5A || got_q[1] !== 8'h96) begin
        errors++;
        $display("FAIL mindiv_data: got %h %h want 5a 96", got_q[0], got_q[1]);
      end
    end
  endtask

  task automatic test_two_stop;
    logic [7:0] exp [2] = '{8'h3C, 8'hC3};
    longint     delta;
    for (int i = 0; i < 2; i++) begin
      got_q.delete();
      got_cyc.delete();
      send_frame(exp[i], 100, 1'b1, 1'b0, -1);
      repeat (10) @(negedge clk);
      checks++;
      if (got_q.size() !== 1) begin
        errors++;
        $display("FAIL twostop_count%0d: got %0d want 1", i, got_q.size());
      end else begin
        checks++;
        if (got_q[0] !== exp[i]) begin
          errors++;
          $display("FAIL twostop_data%0d: got %h want %h", i, got_q[0], exp[i]);
        end
        // The second stop bit spans (10*div, 11*div].
        delta = got_cyc[0] - fall_cyc;
        checks++;
        if (delta <= 1000 || delta > 1100) begin
          errors++;
          $display("FAIL twostop_timing%0d: got %0d want in (1000,1100]", i, delta);
        end
      end
    end
    cfg_nstop = 1'b0;
  endtask

  task automatic test_false_start;
    got_q.delete();
    got_cyc.delete();
    cfg_div = 16'd869;
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (200) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (1000) @(negedge clk);
    checks++;
    if (got_q.size() !== 0) begin
      errors++;
      $display("FAIL false_start_valid: got %0d pulses want 0", got_q.size());
    end
    send_frame(8'h5A, 869, 1'b0, 1'b0, -1);
    repeat (20) @(negedge clk);
    checks++;
    if (got_q.size() !== 1 || rx_data !== 8'h5A) begin
      errors++;
      $display("FAIL false_start_next: got %0d pulses data %h want 1 pulse data 5a",
               got_q.size(), rx_data);
    end
  endtask

  task automatic test_framing_and_enable;
    got_q.delete();
    send_frame(8'h11, 16, 1'b0, 1'b0, -1);
    repeat (10) @(negedge clk);
    checks++;
    if (got_q.size() !== 1 || rx_data !== 8'h11) begin
      errors++;
      $display("FAIL frame_setup: got %0d pulses data %h want 1 pulse data 11",
               got_q.size(), rx_data);
    end
    // Low stop bit: framing error.
    got_q.delete();
    send_frame(8'h81, 16, 1'b0, 1'b1, -1);
    repeat (40) @(negedge clk);
    checks++;
    if (got_q.size() !== 0 || rx_data !== 8'h11) begin
      errors++;
      $display("FAIL framing_err: got %0d pulses data %h want 0 pulses data 11",
               got_q.size(), rx_data);
    end
    // The receiver must re-arm after the error.
    send_frame(8'h7E, 16, 1'b0, 1'b0, -1);
    repeat (10) @(negedge clk);
    checks++;
    if (got_q.size() !== 1 || rx_data !== 8'h7E) begin
      errors++;
      $display("FAIL framing_rearm: got %0d pulses data %h want 1 pulse data 7e",
               got_q.size(), rx_data);
    end
    // Disabled for the whole frame.
    got_q.delete();
    cfg_rxen = 1'b0;
    send_frame(8'h42, 16, 1'b0, 1'b0, -1);
    repeat (20) @(negedge clk);
    checks++;
    if (got_q.size() !== 0 || rx_data !== 8'h7E) begin
      errors++;
      $display("FAIL disabled: got %0d pulses data %h want 0 pulses data 7e",
               got_q.size(), rx_data);
    end
    // Enabled at the start, then dropped at data bit 3 and held low to frame end.
    cfg_rxen = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h42, 16, 1'b0, 1'b0, 3);
    repeat (20) @(negedge clk);
    checks++;
    if (got_q.size() !== 0 || rx_data !== 8'h7E) begin
      errors++;
      $display("FAIL abort: got %0d pulses data %h want 0 pulses data 7e",
               got_q.size(), rx_data);
    end
    cfg_rxen = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h24, 16, 1'b0, 1'b0, -1);
    repeat (10) @(negedge clk);
    checks++;
    if (got_q.size() !== 1 || rx_data !== 8'h24) begin
      errors++;
      $display("FAIL reenable: got %0d pulses data %h want 1 pulse data 24",
               got_q.size(), rx_data);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] b = 8'h99;
    got_q.delete();
    cfg_div = 16'd16;
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = b[i];
      repeat (16) @(negedge clk);
    end
    uart_rxd = b[4];
    repeat (8) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL midreset_out: got valid %b data %h want 0 00", rx_valid, rx_data);
    end
    uart_rxd = 1'b1;
    repeat (5) @(negedge clk);
    rst_b = 1'b0;
    repeat (40) @(negedge clk);
    send_frame(8'h66, 16, 1'b0, 1'b0, -1);
    repeat (10) @(negedge clk);
    checks++;
    if (got_q.size() !== 1 || rx_data !== 8'h66) begin
      errors++;
      $display("FAIL midreset_next: got %0d pulses data %h want 1 pulse data 66",
               got_q.size(), rx_data);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stream();
    test_min_div();
    test_two_stop();
    test_false_start();
    test_framing_and_enable();
    test_reset_mid_frame();
    checks++;
    if (dbl !== 0) begin
      errors++;
      $display("FAIL valid_width: got %0d double-cycle pulses want 0", dbl);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
